// File: rtl/avalon_ctrl_pio_v2.sv
// avalon_ctrl_pio_v2: Avalon-MM control-bit register block.
// WIDTH control lines driven from a DATA register, with atomic set/clear,
// timed auto-clearing pulse bits, a done flag and a maskable interrupt.
// Single-cycle slave: writes on the rising clk edge, reads are combinational.
module avalon_ctrl_pio_v2 #(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int unsigned      PULSE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam int unsigned      CNT_W    = $clog2(PULSE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_SET    = 3'd1,
    REG_CLEAR  = 3'd2,
    REG_PULSE  = 3'd3,
    REG_STATUS = 3'd4
  } reg_e;

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_pulse;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_irq_en;

  reg_e             w_reg;
  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic             w_busy;
  logic             w_expire;
  logic             w_pulse_wr;
  logic             w_status_wr;
  logic             w_unused_wd;

  // Decode the bus strobe and the pulse-engine conditions for this edge
  always_comb begin
    w_reg       = reg_e'(address);
    w_wr        = chipselect & ~write_n;
    w_wd        = writedata[WIDTH-1:0];
    w_busy      = |r_pulse;
    w_expire    = w_busy && (r_cnt == '0);
    w_pulse_wr  = w_wr && (w_reg == REG_PULSE) && (|w_wd);
    w_status_wr = w_wr && (w_reg == REG_STATUS);
    w_unused_wd = ^writedata;
  end

  // DATA register: plain write, atomic set and atomic clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= RESET_VALUE;
    end else if (w_wr) begin
      case (w_reg)
        REG_DATA:  r_data <= w_wd;
        REG_SET:   r_data <= r_data | w_wd;
        REG_CLEAR: r_data <= r_data & ~w_wd;
        default:   r_data <= r_data;
      endcase
    end
  end

  // Pulse bits and their shared down-counter; a new PULSE write always
  // reloads the counter, so every pending bit ends together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pulse <= '0;
      r_cnt   <= '0;
    end else if (w_pulse_wr) begin
      r_pulse <= r_pulse | w_wd;
      r_cnt   <= CNT_LOAD;
    end else if (w_busy) begin
      if (r_cnt == '0) begin
        r_pulse <= '0;
      end else begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

  // Done flag and interrupt enable; expiry beats a clear-done write,
  // and a restart on the expiry edge suppresses the done flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done   <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      if (w_expire && !w_pulse_wr) begin
        r_done <= 1'b1;
      end else if (w_status_wr && writedata[1]) begin
        r_done <= 1'b0;
      end
      if (w_status_wr) begin
        r_irq_en <= writedata[2];
      end
    end
  end

  // Combinational zero-extended read mux and outputs
  always_comb begin
    readdata = '0;
    case (w_reg)
      REG_DATA, REG_SET, REG_CLEAR: readdata[WIDTH-1:0] = r_data;
      REG_PULSE:                    readdata[WIDTH-1:0] = r_pulse;
      REG_STATUS:                   readdata[2:0]       = {r_irq_en, r_done, w_busy};
      default:                      readdata            = '0;
    endcase
    out_port = r_data | r_pulse;
    irq      = r_done & r_irq_en;
  end

endmodule

// File: tb/tb_avalon_ctrl_pio_v2.sv
// Bench for avalon_ctrl_pio_v2 (WIDTH=8, RESET_VALUE=8'hA5, PULSE_CYCLES=4).
module tb_avalon_ctrl_pio_v2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  out;
    logic [31:0] st;
    logic        irq;
  } exp_t;

  exp_t q[$];
  exp_t e;

  avalon_ctrl_pio_v2 #(
    .WIDTH(8),
    .RESET_VALUE(8'hA5),
    .PULSE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic push(input logic [7:0] o, input logic [31:0] s, input logic i, input int n);
    for (int k = 0; k < n; k++) begin
      q.push_back('{out: o, st: s, irq: i});
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    @(negedge clk);
    n_checks++;
    if (out_port !== 8'hA5) begin n_fail++; $display("FAIL reset_out: got %h want a5", out_port); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    rd(3'd0, d);
    n_checks++;
    if (d !== 32'h0000_00A5) begin n_fail++; $display("FAIL reset_rd0: got %h want 000000a5", d); end
    rd(3'd4, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_rd4: got %h want 0", d); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_data_set_clear();
    logic [2:0]  ta [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
    logic [31:0] tw [4] = '{32'h0F, 32'hF0, 32'h3C, 32'hFFFF_FF5A};
    logic [7:0]  tx [4] = '{8'h0F, 8'hFF, 8'hC3, 8'h5A};
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      bus_write(ta[i], tw[i]);
      push(tx[i], {24'h0, tx[i]}, 1'b0, 1);
      @(negedge clk);
      e = q.pop_front();
      n_checks++;
      if (out_port !== e.out) begin n_fail++; $display("FAIL data_out[%0d]: got %h want %h", i, out_port, e.out); end
      rd(3'd0, d);
      n_checks++;
      if (d !== e.st) begin n_fail++; $display("FAIL data_rd0[%0d]: got %h want %h", i, d, e.st); end
    end
  endtask

  task automatic test_pulse();
    logic [31:0] d;
    bus_write(3'd0, 32'h0);
    bus_write(3'd4, 32'h2);
    bus_write(3'd3, 32'h1);
    address = 3'd4;
    push(8'h01, 32'h1, 1'b0, 4);
    push(8'h00, 32'h2, 1'b0, 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      e = q.pop_front();
      n_checks++;
      if (out_port !== e.out || readdata !== e.st || irq !== e.irq)
        begin n_fail++; $display("FAIL pulse[T+%0d]: got out=%h st=%h irq=%b want out=%h st=%h irq=%b", k, out_port, readdata, irq, e.out, e.st, e.irq); end
    end
    // zero-mask PULSE write must not start anything
    bus_write(3'd3, 32'h0);
    @(negedge clk);
    rd(3'd4, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL pulse_zero_st: got %h want 2", d); end
    rd(3'd3, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL pulse_zero_rd3: got %h want 0", d); end
  endtask

  task automatic test_retrigger();
    bus_write(3'd4, 32'h2);
    bus_write(3'd3, 32'h1);
    address = 3'd4;
    push(8'h01, 32'h1, 1'b0, 2);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      e = q.pop_front();
      n_checks++;
      if (out_port !== e.out || readdata !== e.st)
        begin n_fail++; $display("FAIL retrig[T+%0d]: got out=%h st=%h want out=%h st=%h", k, out_port, readdata, e.out, e.st); end
    end
    bus_write(3'd3, 32'h2);
    address = 3'd4;
    push(8'h03, 32'h1, 1'b0, 4);
    push(8'h00, 32'h2, 1'b0, 1);
    for (int k = 3; k <= 7; k++) begin
      @(negedge clk);
      e = q.pop_front();
      n_checks++;
      if (out_port !== e.out || readdata !== e.st)
        begin n_fail++; $display("FAIL retrig[T+%0d]: got out=%h st=%h want out=%h st=%h", k, out_port, readdata, e.out, e.st); end
    end
  endtask

  task automatic test_irq();
    bus_write(3'd4, 32'h6);
    bus_write(3'd3, 32'h1);
    address = 3'd4;
    push(8'h01, 32'h5, 1'b0, 4);
    push(8'h00, 32'h6, 1'b1, 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      e = q.pop_front();
      n_checks++;
      if (out_port !== e.out || readdata !== e.st || irq !== e.irq)
        begin n_fail++; $display("FAIL irq[T+%0d]: got out=%h st=%h irq=%b want out=%h st=%h irq=%b", k, out_port, readdata, irq, e.out, e.st, e.irq); end
    end
    bus_write(3'd4, 32'h6);
    address = 3'd4;
    @(negedge clk);
    n_checks++;
    if (readdata !== 32'h4 || irq !== 1'b0)
      begin n_fail++; $display("FAIL irq_clear: got st=%h irq=%b want st=4 irq=0", readdata, irq); end
  endtask

  task automatic test_clear_at_expiry();
    bus_write(3'd3, 32'h1);
    address = 3'd4;
    push(8'h01, 32'h5, 1'b0, 4);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      e = q.pop_front();
      n_checks++;
      if (out_port !== e.out || readdata !== e.st)
        begin n_fail++; $display("FAIL clr_exp[T+%0d]: got out=%h st=%h want out=%h st=%h", k, out_port, readdata, e.out, e.st); end
    end
    bus_write(3'd4, 32'h6);
    address = 3'd4;
    push(8'h00, 32'h6, 1'b1, 1);
    @(negedge clk);
    e = q.pop_front();
    n_checks++;
    if (out_port !== e.out || readdata !== e.st || irq !== e.irq)
      begin n_fail++; $display("FAIL clr_exp_done: got out=%h st=%h irq=%b want out=%h st=%h irq=%b", out_port, readdata, irq, e.out, e.st, e.irq); end
  endtask

  task automatic test_restart_at_expiry();
    bus_write(3'd4, 32'h6);
    bus_write(3'd3, 32'h1);
    address = 3'd4;
    push(8'h01, 32'h5, 1'b0, 4);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      e = q.pop_front();
      n_checks++;
      if (out_port !== e.out || readdata !== e.st)
        begin n_fail++; $display("FAIL restart[T+%0d]: got out=%h st=%h want out=%h st=%h", k, out_port, readdata, e.out, e.st); end
    end
    bus_write(3'd3, 32'h1);
    address = 3'd4;
    push(8'h01, 32'h5, 1'b0, 4);
    push(8'h00, 32'h6, 1'b1, 1);
    for (int k = 5; k <= 9; k++) begin
      @(negedge clk);
      e = q.pop_front();
      n_checks++;
      if (out_port !== e.out || readdata !== e.st || irq !== e.irq)
        begin n_fail++; $display("FAIL restart[T+%0d]: got out=%h st=%h irq=%b want out=%h st=%h irq=%b", k, out_port, readdata, irq, e.out, e.st, e.irq); end
    end
  endtask

  task automatic test_overlap();
    bus_write(3'd0, 32'h81);
    bus_write(3'd4, 32'h2);
    bus_write(3'd3, 32'h03);
    address = 3'd4;
    push(8'h83, 32'h1, 1'b0, 4);
    push(8'h81, 32'h2, 1'b0, 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      e = q.pop_front();
      n_checks++;
      if (out_port !== e.out || readdata !== e.st)
        begin n_fail++; $display("FAIL overlap[T+%0d]: got out=%h st=%h want out=%h st=%h", k, out_port, readdata, e.out, e.st); end
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [31:0] d;
    bus_write(3'd4, 32'h2);
    bus_write(3'd3, 32'h1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_port !== 8'hA5 || irq !== 1'b0)
      begin n_fail++; $display("FAIL rst_mid_out: got out=%h irq=%b want out=a5 irq=0", out_port, irq); end
    rd(3'd4, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rst_mid_st: got %h want 0", d); end
    rd(3'd3, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rd3: got %h want 0", d); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd(3'd4, d);
    n_checks++;
    if (d !== 32'h0 || out_port !== 8'hA5)
      begin n_fail++; $display("FAIL rst_mid_after: got st=%h out=%h want st=0 out=a5", d, out_port); end
  endtask

  task automatic test_unused_addr();
    logic [31:0] d;
    bus_write(3'd0, 32'h5A);
    for (int a = 5; a <= 7; a++) bus_write(3'(a), 32'hFFFF_FFFF);
    @(negedge clk);
    rd(3'd0, d);
    n_checks++;
    if (d !== 32'h5A || out_port !== 8'h5A)
      begin n_fail++; $display("FAIL unused_data: got rd=%h out=%h want 5a", d, out_port); end
    rd(3'd4, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unused_status: got %h want 0", d); end
    for (int a = 5; a <= 7; a++) begin
      rd(3'(a), d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL unused_rd%0d: got %h want 0", a, d); end
    end
  endtask

  initial begin
    test_reset();
    test_data_set_clear();
    test_pulse();
    test_retrigger();
    test_irq();
    test_clear_at_expiry();
    test_restart_at_expiry();
    test_overlap();
    test_reset_mid_pulse();
    test_unused_addr();
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
